// File: rtl/rolling_window_stats.sv
// Sliding-window mean and mean-of-squares over the last 2**window_log2
// price samples, feeding the Z-score trade stage.
module rolling_window_stats #(
  parameter int data_width  = 16,
  parameter int window_log2 = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      price_valid,
  input  logic [data_width-1:0]     price_in,
  input  logic                      clear,
  output logic [data_width-1:0]     current_data,
  output logic [data_width-1:0]     N_mean,
  output logic [2*data_width-1:0]   N_sqr_mean,
  output logic                      data_valid_pre,
  output logic                      window_full
);

  localparam int N  = 2**window_log2;
  localparam int DW = data_width;
  localparam int SW = data_width + window_log2;
  localparam int QW = 2*data_width + window_log2;
  localparam int FW = window_log2 + 1;
  localparam logic [FW-1:0] FULL = FW'(N);

  logic [DW-1:0]          mem_q [N];
  logic [window_log2-1:0] wr_ptr_q, wr_ptr_d;
  logic [FW-1:0]          fill_q, fill_d;
  logic [SW-1:0]          sum_q, sum_d;
  logic [QW-1:0]          sqsum_q, sqsum_d;

  logic [DW-1:0]          cur_q;
  logic [DW-1:0]          mean_q;
  logic [2*DW-1:0]        sqm_q;
  logic                   dvp_q;

  logic                   accept;
  logic                   full;
  logic [DW-1:0]          old_w;
  logic [2*DW-1:0]        sq_in;
  logic [2*DW-1:0]        sq_old;

  assign accept = price_valid & ~clear;
  assign full   = (fill_q == FULL);

  // Evicted slot only counts once the window has wrapped.
  assign old_w  = full ? mem_q[wr_ptr_q] : '0;
  assign sq_in  = (2*DW)'(price_in) * (2*DW)'(price_in);
  assign sq_old = (2*DW)'(old_w) * (2*DW)'(old_w);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    fill_d   = fill_q;
    sum_d    = sum_q;
    sqsum_d  = sqsum_q;
    if (clear) begin
      wr_ptr_d = '0;
      fill_d   = '0;
      sum_d    = '0;
      sqsum_d  = '0;
    end else if (price_valid) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      fill_d   = full ? FULL : fill_q + FW'(1);
      sum_d    = sum_q + SW'(price_in) - SW'(old_w);
      sqsum_d  = sqsum_q + QW'(sq_in) - QW'(sq_old);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q] <= price_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      fill_q   <= '0;
      sum_q    <= '0;
      sqsum_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      fill_q   <= fill_d;
      sum_q    <= sum_d;
      sqsum_q  <= sqsum_d;
    end
  end

  // Shift by window_log2 is the slice starting at bit window_log2.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q  <= '0;
      mean_q <= '0;
      sqm_q  <= '0;
      dvp_q  <= 1'b0;
    end else begin
      dvp_q <= accept && (fill_d == FULL);
      if (accept) begin
        cur_q  <= price_in;
        mean_q <= sum_d[window_log2 +: DW];
        sqm_q  <= sqsum_d[window_log2 +: 2*DW];
      end
    end
  end

  assign current_data   = cur_q;
  assign N_mean         = mean_q;
  assign N_sqr_mean     = sqm_q;
  assign data_valid_pre = dvp_q;
  assign window_full    = full;

endmodule

// File: tb/tb_rolling_window_stats.sv
// Directed-vector bench for rolling_window_stats.
// Inputs driven and outputs sampled on the falling edge.
module tb_rolling_window_stats;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        price_valid = 1'b0;
  logic [15:0] price_in = '0;
  logic        clear = 1'b0;
  logic [15:0] current_data;
  logic [15:0] N_mean;
  logic [31:0] N_sqr_mean;
  logic        data_valid_pre;
  logic        window_full;

  int vectors = 0;
  int miscompares = 0;
  int pulses = 0;
  bit run_active = 1'b0;

  rolling_window_stats dut (
    .clk            (clk),
    .rst            (rst),
    .price_valid    (price_valid),
    .price_in       (price_in),
    .clear          (clear),
    .current_data   (current_data),
    .N_mean         (N_mean),
    .N_sqr_mean     (N_sqr_mean),
    .data_valid_pre (data_valid_pre),
    .window_full    (window_full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [15:0] v);
    @(negedge clk);
    if (run_active) pulses += int'(data_valid_pre);
    price_valid = 1'b1;
    price_in    = v;
    run_active  = 1'b1;
  endtask

  task automatic finish_run();
    @(negedge clk);
    if (run_active) pulses += int'(data_valid_pre);
    price_valid = 1'b0;
    run_active  = 1'b0;
  endtask

  task automatic feed(input logic [15:0] v, input int n);
    pulses = 0;
    for (int i = 0; i < n; i++) drive(v);
    finish_run();
  endtask

  task automatic check_out(input string tag, input logic [15:0] cur,
                           input logic [15:0] mean, input logic [31:0] sqm);
    check({tag, "_cur"}, 64'(current_data), 64'(cur));
    check({tag, "_mean"}, 64'(N_mean), 64'(mean));
    check({tag, "_sqm"}, 64'(N_sqr_mean), 64'(sqm));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_dvp", 64'(data_valid_pre), 64'd0);
    check("rst_wf", 64'(window_full), 64'd0);
    check_out("rst", 16'h0, 16'h0, 32'h0);

    // Warm-up: 15 samples silent, 16th pulses
    feed(16'h0640, 15);
    check("warm15_pulses", 64'(pulses), 64'd0);
    check("warm15_wf", 64'(window_full), 64'd0);
    feed(16'h0640, 1);
    check("warm16_pulses", 64'(pulses), 64'd1);
    check("warm16_dvp", 64'(data_valid_pre), 64'd1);
    check("warm16_wf", 64'(window_full), 64'd1);
    check_out("warm16", 16'h0640, 16'h0640, 32'h0027_1000);
    @(negedge clk);
    check("idle_dvp", 64'(data_valid_pre), 64'd0);

    // Slide in a new level
    feed(16'h0A40, 1);
    check("slide1_dvp", 64'(data_valid_pre), 64'd1);
    check_out("slide1", 16'h0A40, 16'h0680, 32'h002B_3000);
    feed(16'h0A40, 15);
    check("slide16_pulses", 64'(pulses), 64'd15);
    check_out("slide16", 16'h0A40, 16'h0A40, 32'h0069_1000);

    // Floor truncation: 0..15 gives sum 120, sqsum 1240
    pulses = 0;
    for (int i = 0; i < 16; i++) drive(16'(i));
    finish_run();
    check("trunc_pulses", 64'(pulses), 64'd16);
    check_out("trunc", 16'h000F, 16'h0007, 32'h0000_004D);

    // Gap: outputs hold, no pulses
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("gap_dvp", 64'(data_valid_pre), 64'd0);
      check("gap_mean", 64'(N_mean), 64'h0007);
    end

    // Full-scale samples
    feed(16'hFFFF, 16);
    check("max_pulses", 64'(pulses), 64'd16);
    check_out("max", 16'hFFFF, 16'hFFFF, 32'hFFFE_0001);

    // Clear with valid: sample dropped, warm-up restarts
    @(negedge clk);
    clear = 1'b1;
    price_valid = 1'b1;
    price_in = 16'h1234;
    @(negedge clk);
    clear = 1'b0;
    price_valid = 1'b0;
    check("clr_wf", 64'(window_full), 64'd0);
    check("clr_dvp", 64'(data_valid_pre), 64'd0);
    check("clr_cur", 64'(current_data), 64'hFFFF);
    feed(16'h0640, 15);
    check("clr15_pulses", 64'(pulses), 64'd0);
    check("clr15_wf", 64'(window_full), 64'd0);
    feed(16'h0640, 1);
    check("clr16_dvp", 64'(data_valid_pre), 64'd1);
    check_out("clr16", 16'h0640, 16'h0640, 32'h0027_1000);

    // Reset mid-operation
    feed(16'h0A40, 10);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_dvp", 64'(data_valid_pre), 64'd0);
    check("mrst_wf", 64'(window_full), 64'd0);
    check_out("mrst", 16'h0, 16'h0, 32'h0);
    feed(16'h0640, 16);
    check("mrst16_pulses", 64'(pulses), 64'd1);
    check("mrst16_dvp", 64'(data_valid_pre), 64'd1);
    check("mrst16_wf", 64'(window_full), 64'd1);
    check_out("mrst16", 16'h0640, 16'h0640, 32'h0027_1000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors,
             miscompares);
    $finish;
  end

endmodule

// File: doc/rolling_window_stats.md
Name: rolling_window_stats

Overview:
- Upstream neighbour of the Z-score trade stage.
- Keeps a sliding window of the last N price samples in a circular buffer.
- Maintains an exact running sum and running sum-of-squares over that window.
- Each accepted sample produces a registered window mean, mean of squares and the aligned current sample, together with data_valid_pre, for the Z-score stage to consume directly.

Parameters:
- data_width, 16: price sample width, unsigned fixed point 10.6.
- window_log2, 4: log2 of the window length; N = 2**window_log2 (default 16). Power of two so division is a right shift.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- price_valid  input  1  price_in is valid this cycle; one sample accepted per asserted cycle
- price_in  input  data_width  price sample, 10.6
- clear  input  1  synchronous window flush; restarts warm-up
- current_data  output  data_width  sample that produced this result
- N_mean  output  data_width  window mean, 10.6
- N_sqr_mean  output  2*data_width  window mean of squares, 20.12
- data_valid_pre  output  1  one-cycle pulse: outputs are valid for a full window
- window_full  output  1  high once N samples have been held since reset or clear

Behaviour:
- Storage:
  - N x data_width circular buffer; wr_ptr is window_log2 bits and wraps from N-1 to 0.
  - fill counter saturates at N.
  - sum register is data_width+window_log2 bits.
  - sqsum register is 2*data_width+window_log2 bits.
- Overflow and precision:
  - Both accumulators are wide enough that no overflow is possible.
  - Sums are exact: add incoming, subtract evicted. There is no drift.
- Accept (price_valid=1, clear=0):
  - old = buf[wr_ptr] if fill==N, else 0.
  - buf[wr_ptr] <= price_in; wr_ptr++.
  - sum <= sum + price_in - old.
  - sqsum <= sqsum + price_in*price_in - old*old.
  - fill <= min(fill+1, N).
- Output registers, updated on the cycle after accept (latency 1), from the post-update sums:
  - N_mean = sum_next >> window_log2, truncated to the low data_width bits (floor).
  - N_sqr_mean = sqsum_next >> window_log2, low 2*data_width bits (floor).
  - current_data = price_in.
- data_valid_pre:
  - Asserted for exactly one cycle per accepted sample, only when fill_next == N.
  - The first N-1 samples after reset or clear produce no pulse.
  - The Nth sample produces the first pulse.
- Idle (price_valid=0): all outputs hold their last value; data_valid_pre=0.
- window_full = (fill==N), registered.
- clear: fill, wr_ptr, sum and sqsum go to 0; data_valid_pre=0 next cycle. Buffer contents are don't-care, because they are masked until fill==N.
- Simultaneous clear and price_valid: clear wins and the sample is dropped.
- rst:
  - All outputs go to 0.
  - fill, wr_ptr, sum and sqsum go to 0.
  - Buffer does not need reset.
  - Applies mid-operation with identical effect.
- Back-to-back valid at full rate must be sustained with no bubbles.

Test Plan:
- Warm-up: 16 consecutive samples of 0x0640 (25.0) -> no data_valid_pre for samples 1-15. One cycle after the 16th sample: data_valid_pre=1, N_mean=0x0640, N_sqr_mean=0x00271000, current_data=0x0640, window_full=1.
- Slide: continue with one sample of 0x0A40 -> N_mean=0x0680, N_sqr_mean=0x002B3000, current_data=0x0A40. Then 15 more of 0x0A40 -> N_mean=0x0A40, confirming the original samples were fully evicted.
- Truncation: samples 0x0000..0x000F in order -> N_mean=0x0007 (sum 120, floor of 7.5), N_sqr_mean=0x000004D (1240/16 = 77).
- Max range: 16 samples of 0xFFFF -> N_mean=0xFFFF, N_sqr_mean=0xFFFE0001, no overflow.
- Gaps and clear:
  - Valid low for 5 cycles mid-stream -> outputs hold, data_valid_pre=0.
  - clear asserted together with valid -> that sample is dropped; window_full=0; the next pulse arrives only after 16 new samples.
- Reset mid-operation: assert rst after 10 samples -> all outputs 0 next cycle; the following 16 samples reproduce the warm-up result exactly.
